// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// Request fields are registered by the master and held stable until dmem_ack.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one data-bus transaction per load/store,
// stalls the pipeline meanwhile and hands results to the write-stage register.
module mem_stage_lsu #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_regM,
  input  logic                 mux9M,
  input  logic [31:0]          resultM,
  input  logic [4:0]           rdM,
  input  logic [31:0]          wdataM,
  input  logic [1:0]           cmdM,
  input  logic [2:0]           sx_2M_ctrl,
  input  logic                 flushM,
  input  logic                 hold_in,
  mem_stage_lsu_if.master      dmem,
  output logic                 we_regW,
  output logic                 mux9W,
  output logic [31:0]          resultW,
  output logic [4:0]           rdW,
  output logic [1:0]           cmdW,
  output logic [2:0]           sx_2W_ctrl,
  output logic [31:0]          memW,
  output logic                 stallM,
  output logic                 misalign,
  output logic                 bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_next;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        kill_q;
  logic [TO_W-1:0] cnt;

  logic        memop, mis, issue, timeout_hit, bubble;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  // Decode the access: alignment check, byte lanes and lane-replicated store data.
  always_comb begin
    memop      = (cmdM == 2'b01) || (cmdM == 2'b10);
    mis        = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = wdataM;
    case (sx_2M_ctrl[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << resultM[1:0];
        wdata_calc = {4{wdataM[7:0]}};
      end
      2'b01: begin
        mis        = resultM[0];
        be_calc    = 4'b0011 << resultM[1:0];
        wdata_calc = {2{wdataM[15:0]}};
      end
      default: mis = (resultM[1:0] != 2'b00);
    endcase
  end

  assign timeout_hit = (state == REQ) && !dmem.dmem_ack && (cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    stallM     = 1'b0;
    bubble     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (memop && !flushM) begin
          if (mis) begin
            bubble = 1'b1;
          end else begin
            stallM = 1'b1;
            if (!hold_in) begin
              issue      = 1'b1;
              state_next = REQ;
            end
          end
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (dmem.dmem_ack || timeout_hit) state_next = RESP;
      end
      RESP: begin
        // kill_q covers both a flush seen during REQ and a bus timeout
        if (kill_q) bubble = 1'b1;
        if (!hold_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (stallM || flushM) bubble = 1'b1;
  end

  assign we_regW    = bubble ? 1'b0  : we_regM;
  assign mux9W      = bubble ? 1'b0  : mux9M;
  assign cmdW       = bubble ? 2'b00 : cmdM;
  assign resultW    = resultM;
  assign rdW        = rdM;
  assign sx_2W_ctrl = sx_2M_ctrl;
  assign memW       = rdata_q >> {resultM[1:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      kill_q   <= 1'b0;
      cnt      <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      misalign <= (state == IDLE) && memop && mis && !flushM && !hold_in;
      bus_err  <= timeout_hit;
      case (state)
        IDLE: begin
          kill_q <= 1'b0;
          if (issue) begin
            req_q   <= 1'b1;
            we_q    <= (cmdM == 2'b10);
            addr_q  <= {resultM[31:2], 2'b00};
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            cnt     <= '0;
          end
        end
        REQ: begin
          // A flush never aborts the bus cycle; the result is dropped later
          if (flushM) kill_q <= 1'b1;
          if (dmem.dmem_ack) begin
            req_q   <= 1'b0;
            rdata_q <= dmem.dmem_rdata;
          end else if (timeout_hit) begin
            req_q  <= 1'b0;
            kill_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (!hold_in) kill_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios then random loads/stores/nops,
// with the bench acting as data memory and predicting results per instruction.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        we_regM, mux9M, flushM, hold_in;
  logic [31:0] resultM, wdataM;
  logic [4:0]  rdM;
  logic [1:0]  cmdM;
  logic [2:0]  sx_2M_ctrl;
  logic        we_regW, mux9W, stallM, misalign, bus_err;
  logic [31:0] resultW, memW;
  logic [4:0]  rdW;
  logic [1:0]  cmdW;
  logic [2:0]  sx_2W_ctrl;

  int vectors;
  int miscompares;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .we_regM(we_regM), .mux9M(mux9M), .resultM(resultM), .rdM(rdM),
    .wdataM(wdataM), .cmdM(cmdM), .sx_2M_ctrl(sx_2M_ctrl),
    .flushM(flushM), .hold_in(hold_in),
    .dmem(bus),
    .we_regW(we_regW), .mux9W(mux9W), .resultW(resultW), .rdW(rdW),
    .cmdW(cmdW), .sx_2W_ctrl(sx_2W_ctrl), .memW(memW),
    .stallM(stallM), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [31:0] addr, input int nbytes);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= addr % 4 && i < addr % 4 + nbytes) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nbytes);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    return r;
  endfunction

  task automatic set_nop();
    cmdM = 2'b00; we_regM = 1'b0; mux9M = 1'b0; flushM = 1'b0; hold_in = 1'b0;
    resultM = 32'h0; rdM = 5'd0; wdataM = 32'h0; sx_2M_ctrl = 3'b010;
  endtask

  // One instruction through M, called just after a negedge with the LSU idle.
  // lat = REQ cycles until ack (0 = never ack); hold_resp = extra RESP cycles.
  task automatic apply_stimulus(input string tag, input logic [1:0] cmd, input logic [2:0] sx,
                                input logic [31:0] addr, input logic [31:0] wd, input logic we,
                                input logic m9, input logic [4:0] rd, input int lat,
                                input logic [31:0] rdata, input bit flush_req, input int hold_resp);
    int  nbytes;
    bit  memop, mis, killed;
    nbytes = 1 << sx[1:0];
    memop  = (cmd == 2'b01) || (cmd == 2'b10);
    mis    = memop && (addr % nbytes != 0);
    cmdM = cmd; sx_2M_ctrl = sx; resultM = addr; wdataM = wd;
    we_regM = we; mux9M = m9; rdM = rd; flushM = 1'b0; hold_in = 1'b0;
    #1;
    check_output({tag, ".idle_req"}, bus.dmem_req, 1'b0);
    check_output({tag, ".idle_buserr"}, bus_err, 1'b0);
    check_output({tag, ".idle_misalign"}, misalign, 1'b0);
    check_output({tag, ".sx"}, sx_2W_ctrl, sx);
    check_output({tag, ".rd"}, rdW, rd);
    check_output({tag, ".result"}, resultW, addr);
    if (!memop) begin
      check_output({tag, ".nop_stall"}, stallM, 1'b0);
      check_output({tag, ".nop_we"}, we_regW, we);
      check_output({tag, ".nop_mux9"}, mux9W, m9);
      check_output({tag, ".nop_cmd"}, cmdW, cmd);
      @(negedge clk);
    end else if (mis) begin
      check_output({tag, ".mis_stall"}, stallM, 1'b0);
      check_output({tag, ".mis_we"}, we_regW, 1'b0);
      check_output({tag, ".mis_cmd"}, cmdW, 2'b00);
      @(negedge clk);
      set_nop();
      #1;
      check_output({tag, ".mis_pulse"}, misalign, 1'b1);
      check_output({tag, ".mis_noreq"}, bus.dmem_req, 1'b0);
      @(negedge clk);
    end else begin
      killed = flush_req || (lat == 0);
      check_output({tag, ".issue_stall"}, stallM, 1'b1);
      check_output({tag, ".issue_we"}, we_regW, 1'b0);
      @(negedge clk);
      #1;
      check_output({tag, ".req"}, bus.dmem_req, 1'b1);
      check_output({tag, ".req_we"}, bus.dmem_we, cmd == 2'b10);
      check_output({tag, ".addr"}, bus.dmem_addr, addr - addr % 4);
      check_output({tag, ".be"}, bus.dmem_be, model_be(addr, nbytes));
      check_output({tag, ".wdata"}, bus.dmem_wdata, model_wdata(wd, nbytes));
      check_output({tag, ".req_stall"}, stallM, 1'b1);
      check_output({tag, ".req_bubble"}, cmdW, 2'b00);
      if (flush_req) flushM = 1'b1;
      for (int i = 1; i < ((lat == 0) ? TIMEOUT : lat); i++) begin
        @(negedge clk);
        flushM = 1'b0;
        #1;
        check_output({tag, ".req_held"}, bus.dmem_req, 1'b1);
        check_output({tag, ".req_stall_n"}, stallM, 1'b1);
      end
      if (lat != 0) begin
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
      end
      @(negedge clk);
      flushM = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
      #1;
      check_output({tag, ".resp_req"}, bus.dmem_req, 1'b0);
      check_output({tag, ".resp_stall"}, stallM, 1'b0);
      check_output({tag, ".resp_buserr"}, bus_err, lat == 0);
      check_output({tag, ".resp_we"}, we_regW, killed ? 1'b0 : we);
      check_output({tag, ".resp_mux9"}, mux9W, killed ? 1'b0 : m9);
      check_output({tag, ".resp_cmd"}, cmdW, killed ? 2'b00 : cmd);
      if (cmd == 2'b01 && lat != 0)
        check_output({tag, ".memW"}, memW, rdata >> (8 * (addr % 4)));
      if (hold_resp > 0) begin
        hold_in = 1'b1;
        repeat (hold_resp) begin
          @(negedge clk);
          #1;
          check_output({tag, ".hold_noreq"}, bus.dmem_req, 1'b0);
          check_output({tag, ".hold_stall"}, stallM, 1'b0);
          if (cmd == 2'b01 && lat != 0)
            check_output({tag, ".hold_memW"}, memW, rdata >> (8 * (addr % 4)));
        end
        hold_in = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'h0;
    set_nop();
    $display("[TB] mem_stage_lsu bench start");
    repeat (2) @(negedge clk);
    #1;
    check_output("rst.req", bus.dmem_req, 1'b0);
    check_output("rst.we", bus.dmem_we, 1'b0);
    check_output("rst.addr", bus.dmem_addr, 32'h0);
    check_output("rst.be", bus.dmem_be, 4'h0);
    check_output("rst.wdata", bus.dmem_wdata, 32'h0);
    check_output("rst.misalign", misalign, 1'b0);
    check_output("rst.bus_err", bus_err, 1'b0);
    check_output("rst.stall", stallM, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus("wload",   2'b01, 3'b010, 32'h100, 32'h0,  1'b1, 1'b1, 5'd3, 2, 32'hDEADBEEF, 1'b0, 0);
    apply_stimulus("bstore",  2'b10, 3'b000, 32'h203, 32'hA5, 1'b0, 1'b0, 5'd0, 1, 32'h0,        1'b0, 0);
    apply_stimulus("hload",   2'b01, 3'b001, 32'h102, 32'h0,  1'b1, 1'b1, 5'd7, 1, 32'h80010000, 1'b0, 0);
    apply_stimulus("mis",     2'b01, 3'b010, 32'h101, 32'h0,  1'b1, 1'b1, 5'd4, 1, 32'h0,        1'b0, 0);
    apply_stimulus("timeout", 2'b01, 3'b010, 32'h300, 32'h0,  1'b1, 1'b1, 5'd5, 0, 32'h0,        1'b0, 0);
    apply_stimulus("flushst", 2'b10, 3'b010, 32'h400, 32'h1234, 1'b1, 1'b0, 5'd6, 2, 32'h0,      1'b0, 0);
    apply_stimulus("flushst2",2'b10, 3'b010, 32'h404, 32'h5678, 1'b1, 1'b0, 5'd6, 2, 32'h0,      1'b1, 0);
    apply_stimulus("holdresp",2'b01, 3'b100, 32'h501, 32'h0,  1'b1, 1'b1, 5'd9, 1, 32'hCAFEF00D, 1'b0, 2);

    // Issue must wait while the hazard unit holds the pipeline.
    cmdM = 2'b01; sx_2M_ctrl = 3'b010; resultM = 32'h600; we_regM = 1'b1; hold_in = 1'b1;
    @(negedge clk);
    #1;
    check_output("holdidle.noreq", bus.dmem_req, 1'b0);
    apply_stimulus("holdidle", 2'b01, 3'b010, 32'h600, 32'h0, 1'b1, 1'b1, 5'd1, 3, 32'h01020304, 1'b0, 0);

    // Stray ack while idle must not start or disturb anything.
    set_nop();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    check_output("strayack.req", bus.dmem_req, 1'b0);
    check_output("strayack.stall", stallM, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a request.
    cmdM = 2'b01; sx_2M_ctrl = 3'b010; resultM = 32'h700; we_regM = 1'b1;
    @(negedge clk);
    #1;
    check_output("rstreq.req", bus.dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_output("rstreq.drop", bus.dmem_req, 1'b0);
    check_output("rstreq.be", bus.dmem_be, 4'h0);
    @(negedge clk);
    set_nop();
    rst = 1'b0;
    #1;
    check_output("rstreq.stall", stallM, 1'b0);
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  c;
      logic [2:0]  s;
      int          l;
      c = 2'($urandom_range(0, 3));
      s = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      apply_stimulus($sformatf("rnd%0d", n), c, s, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), l, $urandom, 1'b0,
                     $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
